// File: rtl/arb_pkg.sv
// ============================================================================
// Package     : arb_pkg
// Description : Shared definitions for the priority arbiter controller.
//               Holds the FSM state encoding and the default sizing
//               constants used by priority_arbiter_ctrl and arb_pick.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package arb_pkg;

  localparam int ARB_N_DEFAULT        = 8;
  localparam int ARB_IDXW_DEFAULT     = 3;
  localparam int ARB_MAX_HOLD_DEFAULT = 16;
  localparam int ARB_CNTW_DEFAULT     = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/arb_pick.sv
// ============================================================================
// Module      : arb_pick
// Description : Combinational winner search. Scans i_req_masked starting at
//               index i_start, wrapping modulo N; the first set bit found
//               wins. With i_start = 0 this is a plain lowest-index-first
//               priority encoder.
// Ports       : i_req_masked  [N]    candidate request vector
//               i_start       [IDXW] first index examined
//               o_found              at least one candidate was set
//               o_winner_oh   [N]    one-hot winner (zero when !o_found)
//               o_winner_code [IDXW] binary winner (zero when !o_found)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module arb_pick
  import arb_pkg::*;
#(
  parameter int N    = ARB_N_DEFAULT,
  parameter int IDXW = ARB_IDXW_DEFAULT
) (
  input  logic [N-1:0]    i_req_masked,
  input  logic [IDXW-1:0] i_start,
  output logic            o_found,
  output logic [N-1:0]    o_winner_oh,
  output logic [IDXW-1:0] o_winner_code
);

  logic [IDXW-1:0] w_idx;

  // Walk from the farthest offset back to the start so that the candidate
  // closest to i_start is the last one written and therefore wins.
  // N is a power of two, so the IDXW-bit add wraps modulo N for free.
  always_comb begin
    o_found       = 1'b0;
    o_winner_oh   = '0;
    o_winner_code = '0;
    w_idx         = '0;
    for (int k = N - 1; k >= 0; k--) begin
      w_idx = i_start + IDXW'(k);
      if (i_req_masked[w_idx]) begin
        o_found        = 1'b1;
        o_winner_oh    = '0;
        o_winner_oh[w_idx] = 1'b1;
        o_winner_code  = w_idx;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/priority_arbiter_ctrl.sv
// ============================================================================
// Module      : priority_arbiter_ctrl
// Description : Shares one resource among N requesters. A winner is chosen
//               by arb_pick, granted with a registered one-hot grant plus a
//               binary code, and held while its request stays asserted, up
//               to MAX_HOLD cycles. Every grant is followed by one dead GAP
//               cycle; a requester revoked by the hold limit is excluded from
//               the arbitration done in that GAP cycle.
// Config      : ARB_ROUND_ROBIN_EN - when defined, the search starts just
//               after the previous owner (rotating priority); otherwise
//               index 0 always has the highest priority.
// Ports       : clk                 rising-edge clock
//               rst                 asynchronous active-high reset
//               req       [N]       request vector, bit i = requester i
//               gnt       [N]       registered one-hot grant, zero when idle
//               gnt_code  [IDXW]    binary owner index, zero when !gnt_valid
//               gnt_valid           a grant is active
//               timeout             one-cycle pulse on forced revocation
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module priority_arbiter_ctrl
  import arb_pkg::*;
#(
  parameter int N        = ARB_N_DEFAULT,
  parameter int IDXW     = ARB_IDXW_DEFAULT,
  parameter int MAX_HOLD = ARB_MAX_HOLD_DEFAULT,
  parameter int CNTW     = ARB_CNTW_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  output logic [N-1:0]    gnt,
  output logic [IDXW-1:0] gnt_code,
  output logic            gnt_valid,
  output logic            timeout
);

  localparam logic [CNTW-1:0] C_HOLD_LAST = CNTW'(MAX_HOLD - 1);

  arb_state_t      r_state,      w_state_nxt;
  logic [N-1:0]    r_gnt,        w_gnt_nxt;
  logic [IDXW-1:0] r_gnt_code,   w_gnt_code_nxt;
  logic            r_gnt_valid,  w_gnt_valid_nxt;
  logic            r_timeout,    w_timeout_nxt;
  logic [CNTW-1:0] r_hold_cnt,   w_hold_cnt_nxt;
  logic [IDXW-1:0] r_last_owner, w_last_owner_nxt;
  logic            r_mask_vld,   w_mask_vld_nxt;
  logic [IDXW-1:0] r_mask_idx,   w_mask_idx_nxt;

  logic [N-1:0]    w_mask_oh;
  logic [N-1:0]    w_req_masked;
  logic [IDXW-1:0] w_start;
  logic            w_found;
  logic [N-1:0]    w_win_oh;
  logic [IDXW-1:0] w_win_code;

  // The mask is only ever set while in GAP, so applying it unconditionally
  // has no effect in IDLE.
  assign w_mask_oh    = r_mask_vld ? ({{(N-1){1'b0}}, 1'b1} << r_mask_idx) : '0;
  assign w_req_masked = req & ~w_mask_oh;

`ifdef ARB_ROUND_ROBIN_EN
  assign w_start = r_last_owner + IDXW'(1);
`else
  assign w_start = '0;
`endif

  arb_pick #(
    .N    (N),
    .IDXW (IDXW)
  ) u_pick (
    .i_req_masked  (w_req_masked),
    .i_start       (w_start),
    .o_found       (w_found),
    .o_winner_oh   (w_win_oh),
    .o_winner_code (w_win_code)
  );

  always_comb begin
    w_state_nxt      = r_state;
    w_gnt_nxt        = '0;
    w_gnt_code_nxt   = '0;
    w_gnt_valid_nxt  = 1'b0;
    w_timeout_nxt    = 1'b0;
    w_hold_cnt_nxt   = r_hold_cnt;
    w_last_owner_nxt = r_last_owner;
    w_mask_vld_nxt   = r_mask_vld;
    w_mask_idx_nxt   = r_mask_idx;

    case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_state_nxt      = ST_GRANT;
          w_gnt_nxt        = w_win_oh;
          w_gnt_code_nxt   = w_win_code;
          w_gnt_valid_nxt  = 1'b1;
          w_hold_cnt_nxt   = '0;
          w_last_owner_nxt = w_win_code;
        end
      end

      ST_GRANT: begin
        // A dropped request beats the hold limit on the same edge.
        if (!req[r_last_owner]) begin
          w_state_nxt    = ST_GAP;
          w_mask_vld_nxt = 1'b0;
        end else if (r_hold_cnt == C_HOLD_LAST) begin
          w_state_nxt    = ST_GAP;
          w_timeout_nxt  = 1'b1;
          w_mask_vld_nxt = 1'b1;
          w_mask_idx_nxt = r_last_owner;
        end else begin
          w_gnt_nxt       = r_gnt;
          w_gnt_code_nxt  = r_gnt_code;
          w_gnt_valid_nxt = 1'b1;
          w_hold_cnt_nxt  = r_hold_cnt + CNTW'(1);
        end
      end

      ST_GAP: begin
        w_mask_vld_nxt = 1'b0;
        if (w_found) begin
          w_state_nxt      = ST_GRANT;
          w_gnt_nxt        = w_win_oh;
          w_gnt_code_nxt   = w_win_code;
          w_gnt_valid_nxt  = 1'b1;
          w_hold_cnt_nxt   = '0;
          w_last_owner_nxt = w_win_code;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end

      default: begin
        w_state_nxt    = ST_IDLE;
        w_mask_vld_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_gnt        <= '0;
      r_gnt_code   <= '0;
      r_gnt_valid  <= 1'b0;
      r_timeout    <= 1'b0;
      r_hold_cnt   <= '0;
      r_last_owner <= IDXW'(N - 1);
      r_mask_vld   <= 1'b0;
      r_mask_idx   <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_gnt        <= w_gnt_nxt;
      r_gnt_code   <= w_gnt_code_nxt;
      r_gnt_valid  <= w_gnt_valid_nxt;
      r_timeout    <= w_timeout_nxt;
      r_hold_cnt   <= w_hold_cnt_nxt;
      r_last_owner <= w_last_owner_nxt;
      r_mask_vld   <= w_mask_vld_nxt;
      r_mask_idx   <= w_mask_idx_nxt;
    end
  end

  assign gnt       = r_gnt;
  assign gnt_code  = r_gnt_code;
  assign gnt_valid = r_gnt_valid;
  assign timeout   = r_timeout;

endmodule

`default_nettype wire
